// File: rtl/irq_sequencer_if.sv
// Core/MMIO-side signal bundle for irq_sequencer: peripheral requests, MMIO bus and
// core stall/vector handshake.
interface irq_sequencer_if #(
    parameter int unsigned NSRC = 4
);
    logic [NSRC-1:0] irq;
    logic            we;
    logic [4:0]      addr;
    logic [31:0]     wd;
    logic [31:0]     rd;
    logic [31:0]     pc_current;
    logic            intctrl;
    logic            hold;
    logic            hold_ack;
    logic            eret;
    logic            pc_sel;
    logic [31:0]     vector_pc;
    logic            exl;
    logic [31:0]     epc;

    modport master (
        output irq, we, addr, wd, pc_current, intctrl, hold_ack, eret,
        input  rd, hold, pc_sel, vector_pc, exl, epc
    );

    modport slave (
        input  irq, we, addr, wd, pc_current, intctrl, hold_ack, eret,
        output rd, hold, pc_sel, vector_pc, exl, epc
    );
endinterface

// File: rtl/irq_sequencer.sv
// Interrupt controller / exception sequencer: edge-latched pending requests, software mask,
// hold/hold_ack stall handshake, EPC/cause capture and per-source vectoring.
module irq_sequencer #(
    parameter int unsigned NSRC    = 4,
    parameter logic [31:0] VECTOR  = 32'h180,
    parameter int unsigned VSTRIDE = 8
) (
    input logic            clk,
    input logic            rst,
    irq_sequencer_if.slave bus
);

    localparam logic [4:0] A_MASK  = 5'b11000;
    localparam logic [4:0] A_PEND  = 5'b11001;
    localparam logic [4:0] A_CAUSE = 5'b11010;
    localparam logic [4:0] A_EPC   = 5'b11011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_VECTOR,
        S_SERVICE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] pend_d;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] active;
    logic [2:0]      sel;
    logic [2:0]      cause;
    logic [31:0]     epc_q;
    logic            hold_q;
    logic            pc_sel_q;
    logic            exl_q;
    logic            ack;
    logic            unused_wd;

    assign active    = pending & mask;
    assign unused_wd = ^bus.wd[31:NSRC];

    // Scan from the top so the lowest set index is the last (winning) assignment.
    always_comb begin
        sel = '0;
        for (int unsigned i = NSRC; i > 0; i--) begin
            if (active[i-1]) sel = 3'(i - 1);
        end
    end

    always_comb begin
        state_d = state_q;
        ack     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (active != '0 && !bus.intctrl) state_d = S_REQ;
            end
            S_REQ: begin
                if (active == '0) begin
                    state_d = S_IDLE;
                end else if (bus.hold_ack) begin
                    state_d = S_VECTOR;
                    ack     = 1'b1;
                end
            end
            S_VECTOR: state_d = S_SERVICE;
            S_SERVICE: begin
                if (bus.eret) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Clears (W1C and acknowledge) apply first so a same-edge rising request wins.
    always_comb begin
        pend_d = pending;
        if (bus.we && bus.addr == A_PEND) pend_d = pend_d & ~bus.wd[NSRC-1:0];
        if (ack) pend_d[sel] = 1'b0;
        pend_d = pend_d | (bus.irq & ~irq_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            irq_q    <= '0;
            pending  <= '0;
            mask     <= '0;
            cause    <= '0;
            epc_q    <= '0;
            hold_q   <= 1'b0;
            pc_sel_q <= 1'b0;
            exl_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            irq_q    <= bus.irq;
            pending  <= pend_d;
            if (bus.we && bus.addr == A_MASK) mask <= bus.wd[NSRC-1:0];
            if (ack) begin
                epc_q <= bus.pc_current;
                cause <= sel;
            end
            // Outputs are registered copies decoded from the next state.
            hold_q   <= (state_d == S_REQ) || (state_d == S_VECTOR);
            pc_sel_q <= (state_d == S_VECTOR);
            exl_q    <= (state_d == S_VECTOR) || (state_d == S_SERVICE);
        end
    end

    always_comb begin
        bus.rd = '0;
        case (bus.addr)
            A_MASK:  bus.rd = 32'(mask);
            A_PEND:  bus.rd = 32'(pending);
            A_CAUSE: bus.rd = 32'(cause);
            A_EPC:   bus.rd = epc_q;
            default: bus.rd = '0;
        endcase
    end

    assign bus.hold      = hold_q;
    assign bus.pc_sel    = pc_sel_q;
    assign bus.exl       = exl_q;
    assign bus.epc       = epc_q;
    assign bus.vector_pc = VECTOR + 32'(cause) * 32'(VSTRIDE);

endmodule

// File: tb/tb_irq_sequencer.sv
// Scoreboard bench for irq_sequencer: expected vector/EPC pairs are queued as requests are
// raised and checked by a monitor on every pc_sel pulse; MMIO and timing checked directly.
module tb_irq_sequencer;

    localparam logic [4:0] A_MASK  = 5'b11000;
    localparam logic [4:0] A_PEND  = 5'b11001;
    localparam logic [4:0] A_CAUSE = 5'b11010;
    localparam logic [4:0] A_EPC   = 5'b11011;

    typedef struct packed {
        logic [31:0] vpc;
        logic [31:0] epc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    irq_sequencer_if #(.NSRC(4)) bus ();

    irq_sequencer #(
        .NSRC   (4),
        .VECTOR (32'h180),
        .VSTRIDE(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic mmio_write(input logic [4:0] a, input logic [31:0] d);
        bus.we   = 1'b1;
        bus.addr = a;
        bus.wd   = d;
        tick();
        bus.we   = 1'b0;
        bus.wd   = '0;
    endtask

    task automatic mmio_read(input string name, input logic [4:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        check(name, bus.rd, exp);
    endtask

    task automatic pulse_irq(input logic [3:0] v);
        bus.irq = v;
        tick();
        bus.irq = '0;
    endtask

    task automatic wait_hold(input string name);
        for (int i = 0; i < 20; i++) begin
            if (bus.hold) break;
            tick();
        end
        check(name, 32'(bus.hold), 32'd1);
    endtask

    // Acknowledge one cycle into hold; the VECTOR cycle follows, then SERVICE.
    task automatic acknowledge(input string name);
        bus.hold_ack = 1'b1;
        tick();
        bus.hold_ack = 1'b0;
        check({name, "_vec_pcsel"}, 32'(bus.pc_sel), 32'd1);
        check({name, "_vec_hold"}, 32'(bus.hold), 32'd1);
        tick();
        check({name, "_svc_hold"}, 32'(bus.hold), 32'd0);
        check({name, "_svc_pcsel"}, 32'(bus.pc_sel), 32'd0);
        check({name, "_svc_exl"}, 32'(bus.exl), 32'd1);
    endtask

    task automatic do_eret(input string name);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        check({name, "_exl_clr"}, 32'(bus.exl), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.pc_sel) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pc_sel", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_vector_pc", bus.vector_pc, e.vpc);
                check("mon_epc", bus.epc, e.epc);
                check("mon_exl", 32'(bus.exl), 32'd1);
            end
        end
    end

    initial begin
        bus.irq        = '0;
        bus.we         = 1'b0;
        bus.addr       = '0;
        bus.wd         = '0;
        bus.pc_current = '0;
        bus.intctrl    = 1'b0;
        bus.hold_ack   = 1'b0;
        bus.eret       = 1'b0;
        repeat (3) tick();
        check("rst_hold", 32'(bus.hold), 32'd0);
        check("rst_exl", 32'(bus.exl), 32'd0);
        check("rst_pcsel", 32'(bus.pc_sel), 32'd0);
        check("rst_epc", bus.epc, 32'd0);
        mmio_read("rst_mask", A_MASK, 32'd0);
        mmio_read("rst_pend", A_PEND, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: basic vector for source 0
        mmio_write(A_MASK, 32'h1);
        mmio_read("t1_mask", A_MASK, 32'h1);
        bus.pc_current = 32'h40;
        exp_q.push_back('{vpc: 32'h180, epc: 32'h40});
        pulse_irq(4'b0001);
        check("t1_no_hold_yet", 32'(bus.hold), 32'd0);
        tick();
        check("t1_hold_rise", 32'(bus.hold), 32'd1);
        acknowledge("t1");
        mmio_read("t1_cause", A_CAUSE, 32'd0);
        mmio_read("t1_epc", A_EPC, 32'h40);
        mmio_read("t1_pend", A_PEND, 32'd0);
        do_eret("t1");

        // 2: priority, sources 1 and 3 together
        mmio_write(A_MASK, 32'hF);
        bus.pc_current = 32'h100;
        exp_q.push_back('{vpc: 32'h188, epc: 32'h100});
        pulse_irq(4'b1010);
        wait_hold("t2_hold_a");
        acknowledge("t2a");
        mmio_read("t2_cause_a", A_CAUSE, 32'd1);
        mmio_read("t2_pend_a", A_PEND, 32'h8);
        bus.pc_current = 32'h200;
        exp_q.push_back('{vpc: 32'h198, epc: 32'h200});
        do_eret("t2a");
        check("t2_idle_hold", 32'(bus.hold), 32'd0);
        tick();
        check("t2_rereq_hold", 32'(bus.hold), 32'd1);
        acknowledge("t2b");
        mmio_read("t2_cause_b", A_CAUSE, 32'd3);
        mmio_read("t2_pend_b", A_PEND, 32'd0);
        do_eret("t2b");

        // 3: deferral across control-transfer instructions
        bus.intctrl    = 1'b1;
        bus.pc_current = 32'h2C0;
        pulse_irq(4'b0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_deferred", 32'(bus.hold), 32'd0);
        end
        bus.intctrl = 1'b0;
        exp_q.push_back('{vpc: 32'h190, epc: 32'h2C0});
        tick();
        check("t3_hold_after", 32'(bus.hold), 32'd1);
        acknowledge("t3");
        do_eret("t3");

        // 4: masked request and W1C
        mmio_write(A_MASK, 32'h0);
        pulse_irq(4'b0100);
        tick();
        mmio_read("t4_pend_set", A_PEND, 32'h4);
        check("t4_no_hold", 32'(bus.hold), 32'd0);
        mmio_write(A_PEND, 32'h4);
        mmio_read("t4_pend_clr", A_PEND, 32'h0);
        bus.irq = 4'b0100;
        mmio_write(A_PEND, 32'h4);
        bus.irq = '0;
        mmio_read("t4_set_wins", A_PEND, 32'h4);
        mmio_write(A_PEND, 32'h4);
        mmio_read("t4_pend_final", A_PEND, 32'h0);

        // 5: no nesting while servicing
        mmio_write(A_MASK, 32'h1);
        bus.pc_current = 32'h300;
        exp_q.push_back('{vpc: 32'h180, epc: 32'h300});
        pulse_irq(4'b0001);
        wait_hold("t5_hold");
        acknowledge("t5a");
        pulse_irq(4'b0001);
        for (int i = 0; i < 4; i++) begin
            check("t5_nest_hold", 32'(bus.hold), 32'd0);
            check("t5_nest_exl", 32'(bus.exl), 32'd1);
            tick();
        end
        bus.pc_current = 32'h304;
        exp_q.push_back('{vpc: 32'h180, epc: 32'h304});
        do_eret("t5");
        check("t5_idle_hold", 32'(bus.hold), 32'd0);
        tick();
        check("t5_req_next", 32'(bus.hold), 32'd1);
        acknowledge("t5b");

        // 6a: asynchronous reset while servicing
        #2;
        rst = 1'b1;
        #1;
        check("t6_svc_exl", 32'(bus.exl), 32'd0);
        check("t6_svc_epc", bus.epc, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 6b: asynchronous reset while hold is asserted
        mmio_write(A_MASK, 32'h1);
        pulse_irq(4'b0001);
        wait_hold("t6_hold");
        #2;
        rst = 1'b1;
        #1;
        check("t6_req_hold", 32'(bus.hold), 32'd0);
        check("t6_req_exl", 32'(bus.exl), 32'd0);
        mmio_read("t6_mask", A_MASK, 32'd0);
        mmio_read("t6_pend", A_PEND, 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
Interrupt controller and exception sequencer for the MIPS core. It latches edge-triggered requests from peripherals such as the timer flag and coprocessor done lines. It applies a software mask, then stalls the core through a hold/hold_ack handshake, captures EPC and cause, and steers the PC to a per-source vector. It holds EXL high until the handler executes ERET, and exposes mask/pending/cause/EPC as memory-mapped registers on the dmem address bus.

Parameters:
NSRC, 4, number of interrupt sources (1..8); source 0 has highest priority.
VECTOR, 32'h180, base handler address.
VSTRIDE, 8, byte spacing between per-source vectors.

Ports:
clk  in  1  system clock
rst  in  1  reset
irq  in  NSRC  level request lines; a rising edge sets pending
we  in  1  MMIO write enable
addr  in  5  MMIO word select
wd  in  32  MMIO write data
rd  out  32  MMIO read data (combinational)
pc_current  in  32  PC of the instruction currently in execute
intctrl  in  1  current instruction is a branch/jump/JR; interrupt may not be taken this cycle
hold  out  1  stall request to core
hold_ack  in  1  core confirms it is stalled
eret  in  1  one-cycle pulse: handler return
pc_sel  out  1  one-cycle: core loads vector_pc
vector_pc  out  32  VECTOR + cause*VSTRIDE
exl  out  1  exception level; high while servicing
epc  out  32  captured return PC

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. All state is on posedge clk except rst.
- Reset values: state=IDLE; hold=0, pc_sel=0, exl=0, epc=0, cause=0, mask=0 (all sources disabled), pending=0, irq_q=0.
- Edge detect: irq_q <= irq every cycle. pending[i] sets at the edge where irq[i]=1 and irq_q[i]=0. A held level does not re-trigger.
- MMIO map:
  - 5'b11000 MASK: R/W, low NSRC bits.
  - 5'b11001 PEND: read; a write of 1 clears that bit (W1C).
  - 5'b11010 CAUSE: RO, {29'b0, cause}.
  - 5'b11011 EPC: RO.
  - Other addresses: rd=0, writes ignored. Unused upper bits read 0.
- Simultaneous set and clear on the same pending bit: set wins.
- active = pending & mask. sel = lowest index set in active.
- FSM:
  - IDLE: hold=0. If active!=0 and intctrl=0, go to REQ next edge. If intctrl=1, wait; the interrupt is deferred past the control-transfer instruction.
  - REQ: hold=1. If active becomes 0 (masked or cleared), return to IDLE. If hold_ack=1, go to VECTOR:
    - epc<=pc_current
    - cause<=sel
    - pending[sel] auto-clears (a set on the same edge wins)
    - exl<=1
    - A higher-priority source arriving before hold_ack is the one chosen, since sel is evaluated at the acknowledge edge.
  - VECTOR: one cycle; hold=1, pc_sel=1, vector_pc valid. Next edge goes to SERVICE.
  - SERVICE: hold=0, exl=1. No nesting: new requests only accumulate in pending. eret=1 gives exl<=0 and IDLE next edge; the core returns to epc. If pending is still active, REQ is re-entered one cycle after IDLE.
- eret outside SERVICE is ignored.
- hold_ack outside REQ is ignored.
- hold, pc_sel and exl are registered, decoded from state; there are no combinational paths from inputs to them.
- Minimum latency from irq rise to pc_sel: edge E1 sets pending, E2 enters REQ, hold_ack=1 at E3 enters VECTOR, so pc_sel is high in the cycle after E3.
- vector_pc arithmetic is 32-bit unsigned; cause is 3 bits wide.
- rst mid-sequence (any state) returns to IDLE immediately, with hold/pc_sel/exl deasserted asynchronously.

Test Plan:
1. Basic vector:
   - Stimulus: MASK=4'b0001; pulse irq[0]; hold_ack=1 one cycle after hold rises; pc_current=32'h40.
   - Required: hold for 2 cycles; pc_sel one cycle with vector_pc=32'h180; epc=32'h40; CAUSE=0; exl=1; PEND[0]=0.
2. Priority:
   - Stimulus: MASK=4'b1111; irq[3] and irq[1] rise on the same edge.
   - Required: cause=1, vector_pc=32'h188. After eret, the sequence repeats with cause=3, vector_pc=32'h198.
3. Deferral:
   - Stimulus: pending active while intctrl=1 for 3 cycles.
   - Required: hold stays 0 for those cycles and rises the cycle after intctrl falls.
4. Masking and W1C:
   - Stimulus: MASK=0, pulse irq[2].
   - Required: PEND=4'b0100, no hold. Then write PEND=4'b0100: PEND=0. Then write PEND while irq[2] rises on the same edge: bit stays 1.
5. No nesting and eret:
   - Stimulus: in SERVICE, pulse irq[0].
   - Required: hold stays 0 and exl=1 until eret. Then IDLE, and REQ the following cycle.
6. Reset mid-REQ:
   - Stimulus: assert rst while hold=1.
   - Required: hold=0, exl=0, MASK=0, PEND=0 immediately, without waiting for a clock edge.
